// File: rtl/sale_pkg.sv
// sale_pkg: step-width and one-hot helpers plus default configuration for the sale sequencer
package sale_pkg;
  localparam logic [31:0] COND_MASK_DEF = 32'b0011;
  localparam int TIMEOUT_DEF = 16;
  function automatic int sw(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
  function automatic logic [31:0] onehot(input int idx, input int n);
    return idx < n ? 32'd1 << idx : 32'd0;
  endfunction
endpackage

// File: rtl/sale_wait_tmr.sv
// sale_wait_tmr: wait-step cycle counter that flags the last allowed cycle, tied off when TIMEOUT is 0
module sale_wait_tmr #(
  parameter int TIMEOUT = 16
)(
  input  logic clk,
  input  logic rset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  if (TIMEOUT > 0) begin : g_t
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] wait_cnt;
    assign expired = wait_cnt == W'(TIMEOUT - 1);
    always_ff @(posedge clk)
      if (rset || clr || (en && expired)) wait_cnt <= '0;
      else if (en) wait_cnt <= wait_cnt + W'(1);
  end else begin : g_n
    assign expired = 1'b0;
  end
endmodule

// File: rtl/sale_seq_n.sv
// sale_seq_n: N-step sale sequencer with per-step qualifiers, timeout, abort, done pulse and txn counter
module sale_seq_n import sale_pkg::*; #(
  parameter int N_STEPS = 4,
  parameter logic [31:0] COND_MASK = COND_MASK_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TXN_W = 8,
  localparam int SW = sw(N_STEPS)
)(
  input  logic               clk,
  input  logic               rset,
  input  logic [N_STEPS-1:0] slif,
  input  logic               abort,
  output logic [N_STEPS-1:0] sl,
  output logic [SW-1:0]      count,
  output logic               busy,
  output logic               done,
  output logic               tmo_err,
  output logic               abrt,
  output logic [TXN_W-1:0]   txn_cnt
);
  localparam logic [N_STEPS-1:0] cm = COND_MASK[N_STEPS-1:0] | N_STEPS'(1);
  logic last, adv, ab, go, en, tmo, expired;
  logic [SW-1:0] nxt;
  always_comb begin
    last = count == SW'(N_STEPS - 1);
    adv = cm[count] ? slif[count] : 1'b1;
    ab = abort && count != '0;
    go = !ab && adv;
    en = count != '0 && cm[count] && !adv && !ab;
    tmo = en && expired;
    nxt = (ab || tmo || (go && last)) ? '0 : go ? count + SW'(1) : count;
  end
  sale_wait_tmr #(.TIMEOUT(TIMEOUT)) u_tmr (
    .clk(clk),
    .rset(rset),
    .clr(!en),
    .en(en),
    .expired(expired)
  );
  assign busy = count != '0;
  always_ff @(posedge clk)
    if (rset) begin
      count <= '0;
      sl <= '0;
      done <= 1'b0;
      tmo_err <= 1'b0;
      abrt <= 1'b0;
      txn_cnt <= '0;
    end else begin
      count <= nxt;
      sl <= go ? N_STEPS'(onehot(int'(count), N_STEPS)) : '0;
      done <= go && last;
      tmo_err <= tmo;
      abrt <= ab;
      txn_cnt <= (go && last && !(&txn_cnt)) ? txn_cnt + TXN_W'(1) : txn_cnt;
    end
endmodule
